press_count_display: RTL

PRESS_COUNT_DISPLAY -- requirements
Module: press_count_display

---
 rtl/press_count_display.sv | 124 ++++++++++++
 1 files changed

// File: rtl/press_count_display.sv
// Button press counter: 4-digit BCD count with rollover pulse, multiplexed onto a 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (the ones digit is always shown).
module press_count_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int WRAP_PULSE_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_pulse,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int WRAP_W = $clog2(WRAP_PULSE_W + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [WRAP_W-1:0] WRAP_LOAD = WRAP_W'(WRAP_PULSE_W);

    logic [3:0][3:0]    cnt_q;
    logic [3:0][3:0]    cnt_inc;
    logic               all_nines;
    logic [WRAP_W-1:0]  wrap_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [3:0]         cur_digit;
    logic               blank;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    // Ripple the BCD carry through all four digits in one cycle.
    always_comb begin
        logic carry;
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt_q[i] == 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wrap_cnt <= '0;
        end else begin
            if (clr)
                cnt_q <= '0;
            else if (inc_pulse)
                cnt_q <= cnt_inc;

            // clr neither starts nor cuts short a wrap pulse
            if (inc_pulse && !clr && all_nines)
                wrap_cnt <= WRAP_LOAD;
            else if (wrap_cnt != '0)
                wrap_cnt <= wrap_cnt - WRAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    assign cur_digit = cnt_q[digit_idx];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (digit_idx)
            2'd3:    blank = (cnt_q[3] == 4'd0);
            2'd2:    blank = (cnt_q[3] == 4'd0) && (cnt_q[2] == 4'd0);
            2'd1:    blank = (cnt_q[3] == 4'd0) && (cnt_q[2] == 4'd0) && (cnt_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank ? 7'b1111111 : seg_enc(cur_digit);
        end
    end

    assign count_bcd = cnt_q;
    assign wrap      = (wrap_cnt != '0);

endmodule
